id_ex_stage: RTL and testbench

//  ID/EX pipeline register feeding the ALU (A, B, op). Captures decoded operands and control on

---
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush handling and EX/MEM, MEM/WB operand forwarding.
// Define ID_EX_FWD_EN to enable forwarding; when it is undefined, the registered regfile values feed the ALU directly.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rd1_i,
  input  logic [XLEN-1:0]  id_rd2_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [RF_AW-1:0] id_rs1_i,
  input  logic [RF_AW-1:0] id_rs2_i,
  input  logic [RF_AW-1:0] id_rd_i,
  input  logic [3:0]       id_alu_op_i,
  input  logic             id_asel_i,
  input  logic             id_bsel_i,
  input  logic             id_rf_we_i,
  input  logic             id_mem_we_i,
  input  logic [1:0]       id_wb_sel_i,
  input  logic             exm_we_i,
  input  logic [RF_AW-1:0] exm_rd_i,
  input  logic [XLEN-1:0]  exm_data_i,
  input  logic             mw_we_i,
  input  logic [RF_AW-1:0] mw_rd_i,
  input  logic [XLEN-1:0]  mw_data_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  alu_a_o,
  output logic [XLEN-1:0]  alu_b_o,
  output logic [3:0]       alu_op_o,
  output logic [XLEN-1:0]  ex_store_o,
  output logic [RF_AW-1:0] ex_rd_o,
  output logic             ex_rf_we_o,
  output logic             ex_mem_we_o,
  output logic [1:0]       ex_wb_sel_o
);

  localparam logic [3:0] ALU_OP_ADD = 4'd0;

  logic             valid_r;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  rd1_r;
  logic [XLEN-1:0]  rd2_r;
  logic [XLEN-1:0]  imm_r;
  logic [RF_AW-1:0] rs1_r;
  logic [RF_AW-1:0] rs2_r;
  logic [RF_AW-1:0] rd_r;
  logic [3:0]       op_r;
  logic             asel_r;
  logic             bsel_r;
  logic             rf_we_r;
  logic             mem_we_r;
  logic [1:0]       wb_sel_r;
  logic [XLEN-1:0]  fa_s;
  logic [XLEN-1:0]  fb_s;

`ifdef ID_EX_FWD_EN
  // Forwarding muxes: EX/MEM outranks MEM/WB, and x0 never matches.
  always_comb begin
    fa_s = rd1_r;
    fb_s = rd2_r;
    if (exm_we_i && (exm_rd_i == rs1_r) && (rs1_r != {RF_AW{1'b0}})) begin
      fa_s = exm_data_i;
    end else if (mw_we_i && (mw_rd_i == rs1_r) && (rs1_r != {RF_AW{1'b0}})) begin
      fa_s = mw_data_i;
    end else begin
      fa_s = rd1_r;
    end
    if (exm_we_i && (exm_rd_i == rs2_r) && (rs2_r != {RF_AW{1'b0}})) begin
      fb_s = exm_data_i;
    end else if (mw_we_i && (mw_rd_i == rs2_r) && (rs2_r != {RF_AW{1'b0}})) begin
      fb_s = mw_data_i;
    end else begin
      fb_s = rd2_r;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{exm_we_i, exm_rd_i, exm_data_i, mw_we_i, mw_rd_i, mw_data_i};

  // Without forwarding the operands are the registered regfile values.
  always_comb begin
    fa_s = rd1_r;
    fb_s = rd2_r;
  end
`endif

  // Pipeline register: flush beats stall beats load; an invalid decode slot loads a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r  <= 1'b0;
      pc_r     <= {XLEN{1'b0}};
      rd1_r    <= {XLEN{1'b0}};
      rd2_r    <= {XLEN{1'b0}};
      imm_r    <= {XLEN{1'b0}};
      rs1_r    <= {RF_AW{1'b0}};
      rs2_r    <= {RF_AW{1'b0}};
      rd_r     <= {RF_AW{1'b0}};
      op_r     <= ALU_OP_ADD;
      asel_r   <= 1'b0;
      bsel_r   <= 1'b0;
      rf_we_r  <= 1'b0;
      mem_we_r <= 1'b0;
      wb_sel_r <= 2'b00;
    end else if (flush_i || (!stall_i && !id_valid_i)) begin
      valid_r  <= 1'b0;
      pc_r     <= {XLEN{1'b0}};
      rd1_r    <= {XLEN{1'b0}};
      rd2_r    <= {XLEN{1'b0}};
      imm_r    <= {XLEN{1'b0}};
      rs1_r    <= {RF_AW{1'b0}};
      rs2_r    <= {RF_AW{1'b0}};
      rd_r     <= {RF_AW{1'b0}};
      op_r     <= ALU_OP_ADD;
      asel_r   <= 1'b0;
      bsel_r   <= 1'b0;
      rf_we_r  <= 1'b0;
      mem_we_r <= 1'b0;
      wb_sel_r <= 2'b00;
    end else if (stall_i) begin
      // Capture forwarded values so a producer retiring mid-stall is not lost.
      rd1_r <= fa_s;
      rd2_r <= fb_s;
    end else begin
      valid_r  <= 1'b1;
      pc_r     <= id_pc_i;
      rd1_r    <= id_rd1_i;
      rd2_r    <= id_rd2_i;
      imm_r    <= id_imm_i;
      rs1_r    <= id_rs1_i;
      rs2_r    <= id_rs2_i;
      rd_r     <= id_rd_i;
      op_r     <= id_alu_op_i;
      asel_r   <= id_asel_i;
      bsel_r   <= id_bsel_i;
      rf_we_r  <= id_rf_we_i;
      mem_we_r <= id_mem_we_i;
      wb_sel_r <= id_wb_sel_i;
    end
  end

  assign ex_valid_o  = valid_r;
  assign ex_pc_o     = pc_r;
  assign alu_a_o     = asel_r ? pc_r : fa_s;
  assign alu_b_o     = bsel_r ? imm_r : fb_s;
  assign alu_op_o    = op_r;
  assign ex_store_o  = fb_s;
  assign ex_rd_o     = rd_r;
  assign ex_rf_we_o  = rf_we_r;
  assign ex_mem_we_o = mem_we_r;
  assign ex_wb_sel_o = wb_sel_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX outputs are queued at stimulus time and compared when observed.
module tb_id_ex_stage;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0, flush_i = 1'b0, id_valid_i = 1'b0;
  logic [31:0] id_pc_i = 32'd0, id_rd1_i = 32'd0, id_rd2_i = 32'd0, id_imm_i = 32'd0;
  logic [4:0]  id_rs1_i = 5'd0, id_rs2_i = 5'd0, id_rd_i = 5'd0;
  logic [3:0]  id_alu_op_i = 4'd0;
  logic        id_asel_i = 1'b0, id_bsel_i = 1'b0, id_rf_we_i = 1'b0, id_mem_we_i = 1'b0;
  logic [1:0]  id_wb_sel_i = 2'd0;
  logic        exm_we_i = 1'b0, mw_we_i = 1'b0;
  logic [4:0]  exm_rd_i = 5'd0, mw_rd_i = 5'd0;
  logic [31:0] exm_data_i = 32'd0, mw_data_i = 32'd0;
  logic        ex_valid_o, ex_rf_we_o, ex_mem_we_o;
  logic [31:0] ex_pc_o, alu_a_o, alu_b_o, ex_store_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  ex_rd_o;
  logic [1:0]  ex_wb_sel_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc, a, b, store;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rf_we, mem_we;
    logic [1:0]  wb_sel;
  } exp_t;

  exp_t sb[$];

  id_ex_stage #(.XLEN(32), .RF_AW(5)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_alu_op_i(id_alu_op_i), .id_asel_i(id_asel_i), .id_bsel_i(id_bsel_i),
    .id_rf_we_i(id_rf_we_i), .id_mem_we_i(id_mem_we_i), .id_wb_sel_i(id_wb_sel_i),
    .exm_we_i(exm_we_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
    .mw_we_i(mw_we_i), .mw_rd_i(mw_rd_i), .mw_data_i(mw_data_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_op_o(alu_op_o), .ex_store_o(ex_store_o), .ex_rd_o(ex_rd_o),
    .ex_rf_we_o(ex_rf_we_o), .ex_mem_we_o(ex_mem_we_o), .ex_wb_sel_o(ex_wb_sel_o)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic v, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] st, input logic [3:0] op,
                          input logic [4:0] rd, input logic rfwe, input logic memwe,
                          input logic [1:0] wbs);
    exp_t e;
    e.valid = v; e.pc = pc; e.a = a; e.b = b; e.store = st; e.op = op;
    e.rd = rd; e.rf_we = rfwe; e.mem_we = memwe; e.wb_sel = wbs;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push_exp(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, ALU_OP_ADD, 5'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++; $error("FAIL %s scoreboard empty got %0d exp >0", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++; assert (ex_valid_o === e.valid) else begin errors++; $error("FAIL %s valid got %h exp %h", tag, ex_valid_o, e.valid); end
      checks++; assert (ex_pc_o === e.pc) else begin errors++; $error("FAIL %s pc got %h exp %h", tag, ex_pc_o, e.pc); end
      checks++; assert (alu_a_o === e.a) else begin errors++; $error("FAIL %s alu_a got %h exp %h", tag, alu_a_o, e.a); end
      checks++; assert (alu_b_o === e.b) else begin errors++; $error("FAIL %s alu_b got %h exp %h", tag, alu_b_o, e.b); end
      checks++; assert (ex_store_o === e.store) else begin errors++; $error("FAIL %s store got %h exp %h", tag, ex_store_o, e.store); end
      checks++; assert (alu_op_o === e.op) else begin errors++; $error("FAIL %s op got %h exp %h", tag, alu_op_o, e.op); end
      checks++; assert (ex_rd_o === e.rd) else begin errors++; $error("FAIL %s rd got %h exp %h", tag, ex_rd_o, e.rd); end
      checks++; assert (ex_rf_we_o === e.rf_we) else begin errors++; $error("FAIL %s rf_we got %h exp %h", tag, ex_rf_we_o, e.rf_we); end
      checks++; assert (ex_mem_we_o === e.mem_we) else begin errors++; $error("FAIL %s mem_we got %h exp %h", tag, ex_mem_we_o, e.mem_we); end
      checks++; assert (ex_wb_sel_o === e.wb_sel) else begin errors++; $error("FAIL %s wb_sel got %h exp %h", tag, ex_wb_sel_o, e.wb_sel); end
    end
  endtask

  task automatic id_drive(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] op,
                          input logic asel, input logic bsel, input logic rfwe,
                          input logic memwe, input logic [1:0] wbs);
    id_valid_i = v; id_pc_i = pc; id_rd1_i = rd1; id_rd2_i = rd2; id_imm_i = imm;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd; id_alu_op_i = op;
    id_asel_i = asel; id_bsel_i = bsel; id_rf_we_i = rfwe; id_mem_we_i = memwe; id_wb_sel_i = wbs;
  endtask

  task automatic fwd_clear();
    exm_we_i = 1'b0; exm_rd_i = 5'd0; exm_data_i = 32'd0;
    mw_we_i = 1'b0; mw_rd_i = 5'd0; mw_data_i = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    push_bubble();
    check_out("reset");
    @(negedge clk);
    rst = 1'b0;

    // Plain load, no hazards
    id_drive(1'b1, 32'h100, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd4, ALU_OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    push_exp(1'b1, 32'h100, 32'd5, 32'd7, 32'd7, ALU_OP_ADD, 5'd4, 1'b1, 1'b0, 2'd1);
    tick();
    check_out("load_add");

    // PC and immediate operand selects
    id_drive(1'b1, 32'h200, 32'h8, 32'h9, 32'h40, 5'd7, 5'd8, 5'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
    push_exp(1'b1, 32'h200, 32'h200, 32'h40, 32'h9, 4'd3, 5'd0, 1'b0, 1'b1, 2'd2);
    tick();
    check_out("asel_bsel");

    // Forwarding priority on rs1, then MEM/WB alone, then rs2 match
    id_drive(1'b1, 32'h300, 32'hAA, 32'hBB, 32'd0, 5'd3, 5'd5, 5'd9, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    exm_we_i = 1'b1; exm_rd_i = 5'd3; exm_data_i = 32'h11;
    mw_we_i = 1'b1; mw_rd_i = 5'd3; mw_data_i = 32'h22;
    push_exp(1'b1, 32'h300, FWD ? 32'h11 : 32'hAA, 32'hBB, 32'hBB, 4'd1, 5'd9, 1'b1, 1'b0, 2'd0);
    #1 check_out("fwd_exm_wins");
    exm_we_i = 1'b0;
    push_exp(1'b1, 32'h300, FWD ? 32'h22 : 32'hAA, 32'hBB, 32'hBB, 4'd1, 5'd9, 1'b1, 1'b0, 2'd0);
    #1 check_out("fwd_mw");
    mw_rd_i = 5'd5;
    push_exp(1'b1, 32'h300, 32'hAA, FWD ? 32'h22 : 32'hBB, FWD ? 32'h22 : 32'hBB, 4'd1, 5'd9, 1'b1, 1'b0, 2'd0);
    #1 check_out("fwd_rs2");
    fwd_clear();

    // x0 is never forwarded
    id_drive(1'b1, 32'h400, 32'h66, 32'h77, 32'd0, 5'd0, 5'd0, 5'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    exm_we_i = 1'b1; exm_rd_i = 5'd0; exm_data_i = 32'hFF;
    mw_we_i = 1'b1; mw_rd_i = 5'd0; mw_data_i = 32'hEE;
    push_exp(1'b1, 32'h400, 32'h66, 32'h77, 32'h77, 4'd2, 5'd1, 1'b1, 1'b0, 2'd0);
    #1 check_out("x0_no_fwd");
    fwd_clear();

    // Multi-cycle stall: producer visible only in the first stall cycle
    id_drive(1'b1, 32'h500, 32'h10, 32'h20, 32'd0, 5'd6, 5'd0, 5'd2, ALU_OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    push_exp(1'b1, 32'h500, 32'h10, 32'h20, 32'h20, ALU_OP_ADD, 5'd2, 1'b1, 1'b0, 2'd1);
    tick();
    check_out("pre_stall");
    stall_i = 1'b1;
    id_drive(1'b1, 32'h999, 32'h999, 32'h999, 32'h999, 5'd9, 5'd9, 5'd9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
    mw_we_i = 1'b1; mw_rd_i = 5'd6; mw_data_i = 32'h33;
    push_exp(1'b1, 32'h500, FWD ? 32'h33 : 32'h10, 32'h20, 32'h20, ALU_OP_ADD, 5'd2, 1'b1, 1'b0, 2'd1);
    #1 check_out("stall_c1");
    tick();
    fwd_clear();
    push_exp(1'b1, 32'h500, FWD ? 32'h33 : 32'h10, 32'h20, 32'h20, ALU_OP_ADD, 5'd2, 1'b1, 1'b0, 2'd1);
    #1 check_out("stall_c2");
    push_exp(1'b1, 32'h500, FWD ? 32'h33 : 32'h10, 32'h20, 32'h20, ALU_OP_ADD, 5'd2, 1'b1, 1'b0, 2'd1);
    tick();
    check_out("stall_c3");

    // Stall and flush together: flush wins
    flush_i = 1'b1;
    push_bubble();
    tick();
    check_out("stall_flush");
    stall_i = 1'b0; flush_i = 1'b0;

    // Invalid decode slot loads a bubble
    id_drive(1'b1, 32'h600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
    push_exp(1'b1, 32'h600, 32'h1, 32'h2, 32'h2, 4'd5, 5'd3, 1'b1, 1'b1, 2'd1);
    tick();
    check_out("load_before_invalid");
    id_valid_i = 1'b0;
    push_bubble();
    tick();
    check_out("invalid_bubble");

    // Asynchronous reset mid-cycle while holding a stalled instruction
    id_drive(1'b1, 32'h700, 32'h44, 32'h55, 32'd0, 5'd4, 5'd5, 5'd6, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    tick();
    stall_i = 1'b1;
    #2 rst = 1'b1;
    push_bubble();
    #1 check_out("async_reset");
    id_drive(1'b1, 32'h800, 32'h12, 32'h34, 32'd0, 5'd1, 5'd2, 5'd7, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    @(negedge clk);
    rst = 1'b0; stall_i = 1'b0;
    push_exp(1'b1, 32'h800, 32'h12, 32'h34, 32'h34, 4'd4, 5'd7, 1'b1, 1'b0, 2'd1);
    tick();
    check_out("post_reset_load");

    checks++;
    assert (sb.size() === 0) else begin
      errors++; $error("FAIL sb_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
